// File: rtl/hit_pkg.sv
// Shared types and helpers for the hit stream arbiter.
// Holds default widths, the hit record layout, output FSM states and clog2.
package hit_pkg;

   localparam int HIT_ADDR_W = 8;
   localparam int HIT_LEN_W  = 8;
   localparam int HIT_NUM_CH = 22;

   typedef struct packed {
      logic [HIT_ADDR_W-1:0] q;
      logic [HIT_ADDR_W-1:0] s;
      logic [HIT_LEN_W-1:0]  len;
   } hit_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } out_state_e;

   // Never returns less than 1 so a single-lane build still gets a 1-bit ID.
   function automatic int hit_clog2(input int v);
      int r;
      r = 1;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/hit_lane_fifo.sv
// Single-lane hit FIFO; pointers carry a wrap bit, full/empty by comparison.
// Ports: com_clk, reset (async low), wr/wdata, pop, rdata (head), empty, full.
module hit_lane_fifo
   import hit_pkg::*;
#(
   parameter int W     = 24,
   parameter int DEPTH = 4
) (
   input  logic         com_clk,
   input  logic         reset,
   input  logic         wr,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         empty,
   output logic         full
);

   localparam int AW = hit_clog2(DEPTH);

   logic [AW:0]  wp_q;
   logic [AW:0]  rp_q;
   logic [W-1:0] mem [DEPTH];
   logic         do_wr;
   logic         do_pop;

   assign empty = (wp_q == rp_q);
   assign full  = (wp_q[AW] != rp_q[AW]) &&
                  (wp_q[AW-1:0] == rp_q[AW-1:0]);

   // A full lane still takes a write when its head leaves this cycle.
   assign do_pop = pop & ~empty;
   assign do_wr  = wr & (~full | do_pop);

   always_ff @(posedge com_clk or negedge reset) begin
      if (!reset) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         if (do_wr)  wp_q <= wp_q + {{AW{1'b0}}, 1'b1};
         if (do_pop) rp_q <= rp_q + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge com_clk) begin
      if (do_wr) mem[wp_q[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rp_q[AW-1:0]];

endmodule

// File: rtl/hit_stream_arbiter.sv
// Merges NUM_CH buffered hit lanes into one valid/ready stream with lane ID.
// Ports: hit_wr/q/s/len in, lane_full, out_* stream, drop_count out.
module hit_stream_arbiter
   import hit_pkg::*;
#(
   parameter int NUM_CH    = HIT_NUM_CH,
   parameter int ADDR_W    = HIT_ADDR_W,
   parameter int LEN_W     = HIT_LEN_W,
   parameter int DEPTH     = 4,
   parameter int PRIO_MODE = 0,
   parameter int CNT_W     = 16
) (
   input  logic                         com_clk,
   input  logic                         reset,
   input  logic [NUM_CH-1:0]            hit_wr,
   input  logic [NUM_CH*ADDR_W-1:0]     hit_q,
   input  logic [NUM_CH*ADDR_W-1:0]     hit_s,
   input  logic [NUM_CH*LEN_W-1:0]      hit_len,
   output logic [NUM_CH-1:0]            lane_full,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ADDR_W-1:0]            out_q,
   output logic [ADDR_W-1:0]            out_s,
   output logic [LEN_W-1:0]             out_len,
   output logic [hit_clog2(NUM_CH)-1:0] out_ch,
   output logic [CNT_W-1:0]             drop_count
);

   localparam int W    = 2*ADDR_W + LEN_W;
   localparam int CH_W = hit_clog2(NUM_CH);

   out_state_e        state_q;
   out_state_e        state_d;
   logic [NUM_CH-1:0] empty;
   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] pop;
   logic [NUM_CH-1:0] drop;
   logic [W-1:0]      head [NUM_CH];
   logic [W-1:0]      rec_q;
   logic [CH_W-1:0]   last_grant;
   logic [CH_W-1:0]   sel;
   logic              any;
   logic              load;
   logic              grant;
   logic [CNT_W:0]    ndrop;
   logic [CNT_W:0]    sum;

   for (genvar j = 0; j < NUM_CH; j++) begin : g_lane
      hit_lane_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
         .com_clk (com_clk),
         .reset   (reset),
         .wr      (hit_wr[j]),
         .wdata   ({hit_q[j*ADDR_W +: ADDR_W],
                    hit_s[j*ADDR_W +: ADDR_W],
                    hit_len[j*LEN_W +: LEN_W]}),
         .pop     (pop[j]),
         .rdata   (head[j]),
         .empty   (empty[j]),
         .full    (full[j])
      );
   end

   assign lane_full = full;

   // Scan in reverse search order so the first candidate is written last.
   always_comb begin
      int idx;
      idx = 0;
      any = 1'b0;
      sel = '0;
      if (PRIO_MODE != 0) begin
         for (int i = NUM_CH-1; i >= 0; i--) begin
            if (!empty[i]) begin
               any = 1'b1;
               sel = CH_W'(i);
            end
         end
      end else begin
         for (int i = NUM_CH-1; i >= 0; i--) begin
            idx = int'(last_grant) + 1 + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!empty[idx]) begin
               any = 1'b1;
               sel = CH_W'(idx);
            end
         end
      end
   end

   assign load  = (state_q == ST_EMPTY) || out_ready;
   assign grant = load && any;

   always_ff @(posedge com_clk or negedge reset) begin
      if (!reset) state_q <= ST_EMPTY;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (load) state_d = any ? ST_HOLD : ST_EMPTY;
   end

   always_comb begin
      out_valid = (state_q == ST_HOLD);
      pop       = '0;
      if (grant) pop[sel] = 1'b1;
   end

   always_ff @(posedge com_clk or negedge reset) begin
      if (!reset) begin
         rec_q      <= '0;
         out_ch     <= '0;
         last_grant <= CH_W'(NUM_CH-1);
      end else if (grant) begin
         rec_q      <= head[sel];
         out_ch     <= sel;
         last_grant <= sel;
      end
   end

   assign out_q   = rec_q[W-1 -: ADDR_W];
   assign out_s   = rec_q[LEN_W +: ADDR_W];
   assign out_len = rec_q[LEN_W-1:0];

   assign drop = hit_wr & full & ~pop;

   always_comb begin
      ndrop = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ndrop = ndrop + (CNT_W+1)'(drop[i]);
      end
      sum = {1'b0, drop_count} + ndrop;
   end

   always_ff @(posedge com_clk or negedge reset) begin
      if (!reset)          drop_count <= '0;
      else if (sum[CNT_W]) drop_count <= '1;
      else                 drop_count <= sum[CNT_W-1:0];
   end

endmodule

// File: tb/tb_hit_stream_arbiter.sv
// Directed bench for hit_stream_arbiter: vector table plus corner sequences.
// Instances: dut (round-robin) and dut2 (fixed priority) share clock/reset.
module tb_hit_stream_arbiter;
   import hit_pkg::*;

   localparam int N = 22;

   logic          com_clk = 1'b0;
   logic          reset   = 1'b0;

   logic [N-1:0]   wr, full;
   logic [N*8-1:0] q, s, len;
   logic           valid, rdy;
   logic [7:0]     oq, os, olen;
   logic [4:0]     och;
   logic [15:0]    drop;

   logic [N-1:0]   wr2, full2;
   logic [N*8-1:0] q2, s2, len2;
   logic           valid2, rdy2;
   logic [7:0]     oq2, os2, olen2;
   logic [4:0]     och2;
   logic [15:0]    drop2;

   int checks = 0;
   int errors = 0;

   always #5 com_clk = ~com_clk;

   hit_stream_arbiter #(
      .NUM_CH(N), .ADDR_W(8), .LEN_W(8),
      .DEPTH(4), .PRIO_MODE(0), .CNT_W(16)
   ) dut (
      .com_clk(com_clk), .reset(reset),
      .hit_wr(wr), .hit_q(q), .hit_s(s), .hit_len(len),
      .lane_full(full), .out_valid(valid), .out_ready(rdy),
      .out_q(oq), .out_s(os), .out_len(olen),
      .out_ch(och), .drop_count(drop)
   );

   hit_stream_arbiter #(
      .NUM_CH(N), .ADDR_W(8), .LEN_W(8),
      .DEPTH(4), .PRIO_MODE(1), .CNT_W(16)
   ) dut2 (
      .com_clk(com_clk), .reset(reset),
      .hit_wr(wr2), .hit_q(q2), .hit_s(s2), .hit_len(len2),
      .lane_full(full2), .out_valid(valid2), .out_ready(rdy2),
      .out_q(oq2), .out_s(os2), .out_len(olen2),
      .out_ch(och2), .drop_count(drop2)
   );

   typedef struct {
      logic [N-1:0] wr;
      logic [7:0]   q;
      logic [7:0]   s;
      logic [7:0]   l;
      logic         rdy;
      logic         ev;
      logic [4:0]   ech;
      logic [7:0]   eq;
      logic [7:0]   es;
      logic [7:0]   el;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic check_out(input string nm, input logic ev,
                            input logic [4:0] ech, input logic [7:0] eq,
                            input logic [7:0] es, input logic [7:0] el);
      chk({nm, "_valid"}, 32'(valid), 32'(ev));
      if (ev) begin
         chk({nm, "_ch"},  32'(och),  32'(ech));
         chk({nm, "_q"},   32'(oq),   32'(eq));
         chk({nm, "_s"},   32'(os),   32'(es));
         chk({nm, "_len"}, 32'(olen), 32'(el));
      end
   endtask

   task automatic tick();
      @(posedge com_clk);
      #1;
   endtask

   task automatic set_lane(input int j, input logic [7:0] vq,
                           input logic [7:0] vs, input logic [7:0] vl);
      wr[j]        = 1'b1;
      q[j*8 +: 8]   = vq;
      s[j*8 +: 8]   = vs;
      len[j*8 +: 8] = vl;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      wr = '0; q = '0; s = '0; len = '0; rdy = 1'b0;
      wr2 = '0; q2 = '0; s2 = '0; len2 = '0; rdy2 = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [4:0] bp_ch [6];
      logic [3:0] bp_tag [6];
      logic       bp_rdy [6];
      logic [7:0] tq;

      tbl[0] = '{22'h20, 8'h12, 8'h34, 8'h07, 1'b1,
                 1'b0, 5'd0, 8'h00, 8'h00, 8'h00};
      tbl[1] = '{22'h0, 8'h00, 8'h00, 8'h00, 1'b1,
                 1'b1, 5'd5, 8'h12, 8'h34, 8'h07};
      tbl[2] = '{22'h0, 8'h00, 8'h00, 8'h00, 1'b1,
                 1'b0, 5'd0, 8'h00, 8'h00, 8'h00};
      tbl[3] = '{22'h12, 8'hAA, 8'hBB, 8'h01, 1'b0,
                 1'b0, 5'd0, 8'h00, 8'h00, 8'h00};
      tbl[4] = '{22'h0, 8'h00, 8'h00, 8'h00, 1'b0,
                 1'b1, 5'd1, 8'hAA, 8'hBB, 8'h01};
      tbl[5] = '{22'h0, 8'h00, 8'h00, 8'h00, 1'b0,
                 1'b1, 5'd1, 8'hAA, 8'hBB, 8'h01};
      tbl[6] = '{22'h0, 8'h00, 8'h00, 8'h00, 1'b1,
                 1'b1, 5'd4, 8'hAA, 8'hBB, 8'h01};
      tbl[7] = '{22'h1, 8'h01, 8'h02, 8'h03, 1'b1,
                 1'b0, 5'd0, 8'h00, 8'h00, 8'h00};
      tbl[8] = '{22'h0, 8'h00, 8'h00, 8'h00, 1'b1,
                 1'b1, 5'd0, 8'h01, 8'h02, 8'h03};
      tbl[9] = '{22'h0, 8'h00, 8'h00, 8'h00, 1'b1,
                 1'b0, 5'd0, 8'h00, 8'h00, 8'h00};

      bp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      bp_ch  = '{5'd1, 5'd1, 5'd1, 5'd0, 5'd1, 5'd0};
      bp_tag = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd0};

      // reset state
      do_reset();
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_q",     32'(oq),    32'd0);
      chk("rst_s",     32'(os),    32'd0);
      chk("rst_len",   32'(olen),  32'd0);
      chk("rst_ch",    32'(och),   32'd0);
      chk("rst_drop",  32'(drop),  32'd0);
      chk("rst_full",  32'(full),  32'd0);

      // vector table
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < N; j++)
            if (tbl[i].wr[j]) set_lane(j, tbl[i].q, tbl[i].s, tbl[i].l);
         rdy = tbl[i].rdy;
         tick();
         wr = '0;
         check_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ech,
                   tbl[i].eq, tbl[i].es, tbl[i].el);
      end
      chk("vec_drop", 32'(drop), 32'd0);

      // all lanes at once, round-robin from lane 0
      do_reset();
      for (int j = 0; j < N; j++)
         set_lane(j, 8'(j), 8'(8'h80 + j), 8'(8'hF0 ^ j));
      rdy = 1'b1;
      tick();
      wr = '0;
      for (int i = 0; i < N; i++) begin
         tick();
         check_out($sformatf("all%0d", i), 1'b1, 5'(i), 8'(i),
                   8'(8'h80 + i), 8'(8'hF0 ^ i));
      end
      tick();
      check_out("all_end", 1'b0, 5'd0, 8'h0, 8'h0, 8'h0);
      chk("all_drop", 32'(drop), 32'd0);

      // lane 3 overflow while output holds a lane 0 record
      do_reset();
      rdy = 1'b0;
      set_lane(0, 8'h50, 8'h51, 8'h52);
      tick();
      wr = '0;
      tick();
      check_out("ovf_hold", 1'b1, 5'd0, 8'h50, 8'h51, 8'h52);
      for (int k = 0; k < 6; k++) begin
         set_lane(3, 8'(8'h30 + k), 8'(8'h60 + k), 8'(k));
         tick();
         wr = '0;
         chk($sformatf("ovf_full%0d", k), 32'(full[3]),
             32'(k >= 3));
      end
      chk("ovf_drop", 32'(drop), 32'd2);
      check_out("ovf_still", 1'b1, 5'd0, 8'h50, 8'h51, 8'h52);
      rdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check_out($sformatf("ovf_rd%0d", k), 1'b1, 5'd3,
                   8'(8'h30 + k), 8'(8'h60 + k), 8'(k));
      end
      tick();
      check_out("ovf_end", 1'b0, 5'd0, 8'h0, 8'h0, 8'h0);
      chk("ovf_drop2", 32'(drop), 32'd2);

      // backpressure on lanes 0 and 1
      do_reset();
      rdy = 1'b0;
      for (int t = 1; t <= 2; t++) begin
         for (int j = 0; j < 2; j++) begin
            tq = 8'(j*16 + t);
            set_lane(j, tq, ~tq, tq ^ 8'h5A);
         end
         tick();
         wr = '0;
      end
      tq = 8'h01;
      check_out("bp_first", 1'b1, 5'd0, tq, ~tq, tq ^ 8'h5A);
      for (int i = 0; i < 6; i++) begin
         rdy = bp_rdy[i];
         tick();
         tq = 8'(bp_ch[i]*16 + bp_tag[i]);
         check_out($sformatf("bp%0d", i), (i < 5), bp_ch[i],
                   tq, ~tq, tq ^ 8'h5A);
      end

      // fixed priority: lane 2 starves lane 7 while refilled
      do_reset();
      rdy2 = 1'b1;
      for (int c = 0; c < 10; c++) begin
         wr2 = 22'h84;
         q2[2*8 +: 8] = 8'(c);
         q2[7*8 +: 8] = 8'(c);
         tick();
         wr2 = '0;
         if (c >= 1) begin
            chk($sformatf("prio_ch%0d", c), 32'(och2), 32'd2);
            chk($sformatf("prio_q%0d", c), 32'(oq2), 32'(c - 1));
         end
      end
      tick();
      chk("prio_last2", 32'(och2), 32'd2);
      chk("prio_last2q", 32'(oq2), 32'd9);
      tick();
      chk("prio_l7", 32'(och2), 32'd7);
      chk("prio_l7q", 32'(oq2), 32'd0);
      chk("prio_drop", 32'(drop2), 32'd6);

      // reset mid-operation
      do_reset();
      rdy = 1'b0;
      for (int c = 0; c < 6; c++) begin
         for (int j = 4; j < 7; j++)
            set_lane(j, 8'(8'h40 + c), 8'h77, 8'h11);
         tick();
         wr = '0;
      end
      check_out("mid_pre", 1'b1, 5'd4, 8'h40, 8'h77, 8'h11);
      chk("mid_pre_drop", 32'(drop), 32'd5);
      chk("mid_pre_full", 32'(full), 32'h70);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_valid", 32'(valid), 32'd0);
      chk("mid_q",     32'(oq),    32'd0);
      chk("mid_s",     32'(os),    32'd0);
      chk("mid_len",   32'(olen),  32'd0);
      chk("mid_ch",    32'(och),   32'd0);
      chk("mid_drop",  32'(drop),  32'd0);
      chk("mid_full",  32'(full),  32'd0);
      tick();
      reset = 1'b1;
      rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("mid_post%0d", i), 32'(valid), 32'd0);
      end
      chk("mid_post_drop", 32'(drop), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
